// File: rtl/fifo_rd_pkg.sv
// Shared types and sizing helpers for the FIFO read-side stream engine.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } rd_state_e;

  localparam int MIN_BUF_DEPTH = 3;
  localparam int MAX_BUF_DEPTH = 8;

  // Wide enough to hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Valid/ready stream carrying words popped from the sync FIFO to a consumer.
interface fifo_rd_stream_if #(
  parameter int DATA_W = 8
);
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/fifo_rd_skid_buf.sv
// Circular skid buffer between FIFO read data and the stream output.
// Flush beats push and pop; the head reads as zero while the buffer is empty.
module fifo_rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BUF_DEPTH = 3,
  localparam int CW       = cnt_width(BUF_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wdata,
  output logic [CW-1:0]     cnt,
  output logic [DATA_W-1:0] head
);
  localparam int PW = ptr_width(BUF_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(BUF_DEPTH - 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  if ((BUF_DEPTH < MIN_BUF_DEPTH) || (BUF_DEPTH > MAX_BUF_DEPTH)) begin : g_depth_check
    $error("fifo_rd_skid_buf: BUF_DEPTH out of range");
  end

  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: the head is masked whenever cnt is zero.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign head = (cnt != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side engine: pops the sync FIFO and presents words on a valid/ready stream.
// Optional build macro FIFO_RD_STATS_EN adds word_cnt / underrun_cnt outputs.
//
// state | meaning
// IDLE  | not reading; buffered words may still drain
// RUN   | issuing FIFO reads while space and data are available
// STOP  | en dropped; no new reads, waiting for the in-flight word to land
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BUF_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              flush,
  input  logic              empty,
  input  logic [DATA_W-1:0] rd_data,
  output logic              rd_en,
  output logic              busy,
`ifdef FIFO_RD_STATS_EN
  output logic [31:0]       word_cnt,
  output logic [31:0]       underrun_cnt,
`endif
  fifo_rd_stream_if.master  strm
);
  localparam int CW = cnt_width(BUF_DEPTH);
  localparam logic [CW:0] FILL_MAX = (CW + 1)'(BUF_DEPTH);

  rd_state_e         state;
  rd_state_e         state_nxt;
  logic              inflight_q;
  logic [CW-1:0]     cnt;
  logic [CW:0]       fill;
  logic              handshake;
  logic [DATA_W-1:0] head;

  // Reserving a slot for the in-flight word keeps rd_en independent of m_ready.
  assign fill      = {1'b0, cnt} + {{CW{1'b0}}, inflight_q};
  assign rd_en     = en && !flush && !empty && (state == RUN) && (fill < FILL_MAX);
  assign handshake = strm.m_valid && strm.m_ready;
  assign busy      = (state != IDLE) || (cnt != '0);

  assign strm.m_valid = (cnt != '0);
  assign strm.m_data  = head;

  fifo_rd_skid_buf #(
    .DATA_W   (DATA_W),
    .BUF_DEPTH(BUF_DEPTH)
  ) u_skid_buf (
    .clk  (clk),
    .rst_n(rst_n),
    .push (inflight_q),
    .pop  (handshake),
    .flush(flush),
    .wdata(rd_data),
    .cnt  (cnt),
    .head (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      inflight_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      inflight_q <= rd_en;
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = en ? RUN : IDLE;
    end else begin
      case (state)
        IDLE:    if (en) state_nxt = RUN;
        RUN:     if (!en) state_nxt = STOP;
        STOP: begin
          if (en)               state_nxt = RUN;
          else if (!inflight_q) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

`ifdef FIFO_RD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt     <= '0;
      underrun_cnt <= '0;
    end else begin
      if (handshake && (word_cnt != '1))
        word_cnt <= word_cnt + 32'd1;
      if (en && empty && (cnt == '0) && !inflight_q && (underrun_cnt != '1))
        underrun_cnt <= underrun_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: a queue-based FIFO model feeds the DUT,
// every word popped is expected on the stream in order unless flushed or reset.
module tb_fifo_rd_stream;
  localparam int DATA_W    = 8;
  localparam int BUF_DEPTH = 3;

  logic              clk     = 1'b0;
  logic              rst_n   = 1'b0;
  logic              en      = 1'b0;
  logic              flush   = 1'b0;
  logic              empty   = 1'b1;
  logic [DATA_W-1:0] rd_data = '0;
  logic              rd_en;
  logic              busy;
`ifdef FIFO_RD_STATS_EN
  logic [31:0]       word_cnt;
  logic [31:0]       underrun_cnt;
`endif

  fifo_rd_stream_if #(.DATA_W(DATA_W)) strm_if ();

  fifo_rd_stream #(
    .DATA_W   (DATA_W),
    .BUF_DEPTH(BUF_DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .flush       (flush),
    .empty       (empty),
    .rd_data     (rd_data),
    .rd_en       (rd_en),
    .busy        (busy),
`ifdef FIFO_RD_STATS_EN
    .word_cnt    (word_cnt),
    .underrun_cnt(underrun_cnt),
`endif
    .strm        (strm_if)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         rd_cycles[$];
  int         dlv_cycles[$];
  logic [7:0] dlv_data[$];
  logic [7:0] fl_word;
  bit         fl_valid;
  int         valid_cnt;
  int         hs_total;

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic fifo_load(input logic [7:0] w);
    fifo_q.push_back(w);
    empty = 1'b0;
  endtask

  task automatic fifo_clear();
    fifo_q.delete();
    empty = 1'b1;
  endtask

  // One clock: sample at negedge, model the FIFO pop, then present rd_data/empty after the edge.
  task automatic step();
    @(negedge clk);
    chk("no_underflow", 32'(rd_en && empty), 0);
    if (strm_if.m_valid) valid_cnt++;
    fl_valid = 1'b0;
    if (rd_en && (fifo_q.size() > 0)) begin
      fl_word  = fifo_q.pop_front();
      fl_valid = 1'b1;
      exp_q.push_back(fl_word);
      rd_cycles.push_back(cyc);
    end
    if (flush) exp_q.delete();
    @(posedge clk);
    #1;
    rd_data = fl_valid ? fl_word : 8'($urandom);
    empty   = (fifo_q.size() == 0);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic clear_logs();
    rd_cycles.delete();
    dlv_cycles.delete();
    dlv_data.delete();
    valid_cnt = 0;
  endtask

  task automatic monitor();
    logic       hold = 1'b0;
    logic [7:0] hold_data = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (hold) begin
          chk("stall_valid_held", 32'(strm_if.m_valid), 1);
          chk("stall_data_stable", 32'(strm_if.m_data), 32'(hold_data));
        end
        if (strm_if.m_valid && strm_if.m_ready) begin
          hs_total++;
          if (!flush) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_word_queue", exp_q.size(), 1);
            end else begin
              chk("stream_data", 32'(strm_if.m_data), 32'(exp_q.pop_front()));
              dlv_cycles.push_back(cyc);
              dlv_data.push_back(strm_if.m_data);
            end
          end
        end
        hold      = strm_if.m_valid && !strm_if.m_ready && !flush;
        hold_data = strm_if.m_data;
      end else begin
        hold = 1'b0;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t1_w [4];
    logic [7:0] t2_w [8];
    logic [7:0] t6_next;
    logic [31:0] u0;

    t1_w = '{8'h11, 8'h22, 8'h33, 8'h44};
    u0 = '0;
    hs_total = 0;
    strm_if.m_ready = 1'b0;
    fork
      monitor();
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_m_valid", 32'(strm_if.m_valid), 0);
    chk("rst_m_data", 32'(strm_if.m_data), 0);
    chk("rst_busy", 32'(busy), 0);
`ifdef FIFO_RD_STATS_EN
    chk("rst_word_cnt", int'(word_cnt), 0);
    chk("rst_underrun_cnt", int'(underrun_cnt), 0);
`endif
    rst_n = 1'b1;

    // Four preloaded words, consumer always ready
    clear_logs();
    foreach (t1_w[i]) fifo_load(t1_w[i]);
    en = 1'b1;
    strm_if.m_ready = 1'b1;
    run(12);
    chk("t1_read_count", rd_cycles.size(), 4);
    chk("t1_deliver_count", dlv_data.size(), 4);
    if (rd_cycles.size() == 4 && dlv_data.size() == 4) begin
      chk("t1_reads_back_to_back", rd_cycles[3] - rd_cycles[0], 3);
      chk("t1_first_valid_latency", dlv_cycles[0] - rd_cycles[0], 2);
      chk("t1_delivery_no_gaps", dlv_cycles[3] - dlv_cycles[0], 3);
      foreach (t1_w[i]) chk("t1_word_order", 32'(dlv_data[i]), 32'(t1_w[i]));
    end

    // Empty FIFO with en held high
    clear_logs();
`ifdef FIFO_RD_STATS_EN
    u0 = underrun_cnt;
`endif
    run(5);
    chk("t3_no_reads_when_empty", rd_cycles.size(), 0);
    chk("t3_no_valid_when_empty", valid_cnt, 0);
`ifdef FIFO_RD_STATS_EN
    chk("t3_underrun_delta", int'(underrun_cnt - u0), 5);
`endif

    // Consumer stalled with eight words waiting
    clear_logs();
    strm_if.m_ready = 1'b0;
    foreach (t2_w[i]) begin
      t2_w[i] = 8'($urandom);
      fifo_load(t2_w[i]);
    end
    run(10);
    chk("t2_reads_while_stalled", rd_cycles.size(), BUF_DEPTH);
    chk("t2_valid_while_stalled", 32'(strm_if.m_valid), 1);
    chk("t2_head_is_first_word", 32'(strm_if.m_data), 32'(t2_w[0]));
    strm_if.m_ready = 1'b1;
    run(12);
    chk("t2_deliver_count", dlv_data.size(), 8);
    if (dlv_data.size() == 8) begin
      chk("t2_delivery_no_gaps", dlv_cycles[7] - dlv_cycles[0], 7);
      foreach (t2_w[i]) chk("t2_word_order", 32'(dlv_data[i]), 32'(t2_w[i]));
    end

    // Flush while 0xAA is in flight and two words are buffered
    clear_logs();
    strm_if.m_ready = 1'b0;
    fifo_load(8'h01);
    fifo_load(8'h02);
    fifo_load(8'hAA);
    fifo_load(8'hBB);
    for (int i = 0; i < 20 && rd_cycles.size() < 3; i++) step();
    chk("t4_reads_before_flush", rd_cycles.size(), 3);
    chk("t4_head_before_flush", 32'(strm_if.m_data), 'h01);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t4_valid_after_flush", 32'(strm_if.m_valid), 0);
    strm_if.m_ready = 1'b1;
    run(8);
    chk("t4_deliver_count", dlv_data.size(), 1);
    if (dlv_data.size() >= 1) chk("t4_next_word", 32'(dlv_data[0]), 'hBB);

    // en dropped with one read in flight
    clear_logs();
    fifo_load(8'h5C);
    for (int i = 0; i < 20 && rd_cycles.size() < 1; i++) step();
    en = 1'b0;
    fifo_load(8'h66);
    fifo_load(8'h77);
    step();
    chk("t5_busy_in_stop", 32'(busy), 1);
    run(6);
    chk("t5_no_reads_after_stop", rd_cycles.size(), 1);
    chk("t5_deliver_count", dlv_data.size(), 1);
    if (dlv_data.size() >= 1) chk("t5_inflight_word", 32'(dlv_data[0]), 'h5C);
    chk("t5_busy_after_drain", 32'(busy), 0);
    fifo_clear();

    // Asynchronous reset mid-stream
    clear_logs();
    strm_if.m_ready = 1'b0;
    for (int i = 0; i < 6; i++) fifo_load(8'hA0 + 8'(i));
    en = 1'b1;
    for (int i = 0; i < 20 && rd_cycles.size() < 2; i++) step();
    step();
    chk("t6_valid_before_reset", 32'(strm_if.m_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rd_en_in_reset", 32'(rd_en), 0);
    chk("t6_m_valid_in_reset", 32'(strm_if.m_valid), 0);
    chk("t6_m_data_in_reset", 32'(strm_if.m_data), 0);
    chk("t6_busy_in_reset", 32'(busy), 0);
    exp_q.delete();
    hs_total = 0;
    t6_next = fifo_q[0];
    run(2);
    rst_n = 1'b1;
    strm_if.m_ready = 1'b1;
    clear_logs();
    run(10);
    chk("t6_deliver_count", dlv_data.size(), 3);
    if (dlv_data.size() >= 1) chk("t6_first_after_reset", 32'(dlv_data[0]), 32'(t6_next));

    // Randomized traffic against the scoreboard
    for (int i = 0; i < 3000; i++) begin
      en              = ($urandom_range(0, 9) != 0);
      strm_if.m_ready = ($urandom_range(0, 9) < 7);
      flush           = ($urandom_range(0, 49) == 0);
      if (fifo_q.size() < 6 && $urandom_range(0, 2) != 0) fifo_load(8'($urandom));
      step();
    end
    flush = 1'b0;
    en = 1'b0;
    strm_if.m_ready = 1'b1;
    for (int i = 0; i < 50 && (exp_q.size() != 0 || busy); i++) step();
    chk("drain_scoreboard_empty", exp_q.size(), 0);
    chk("drain_busy", 32'(busy), 0);
`ifdef FIFO_RD_STATS_EN
    chk("stats_word_cnt", int'(word_cnt), hs_total);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
Read-side engine for the team's synchronous FIFO. It pops words through the FIFO's rd_en/empty/rd_data interface and presents them on a valid/ready stream. It never issues a read while empty is high. An internal 3-entry skid buffer sustains one word per cycle without a combinational path from m_ready to rd_en. It sits between the sync FIFO and any downstream stream consumer, and is the reader counterpart of the FIFO writer/producer logic.

Parameters:
DATA_W, 8, width of FIFO data and stream data
BUF_DEPTH, 3, skid buffer entries; legal range 3..8 (3 is the minimum for full throughput)

Ports:
clk  in  1  clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
en  in  1  read enable; 0 stops issuing new FIFO reads
flush  in  1  synchronous; discards buffer contents and in-flight data
empty  in  1  FIFO empty flag
rd_data  in  DATA_W  FIFO read data, valid 1 cycle after rd_en
rd_en  out  1  FIFO pop request
m_valid  out  1  stream data valid
m_ready  in  1  stream consumer ready
m_data  out  DATA_W  stream data
busy  out  1  1 when state != IDLE or buffer nonempty

Behaviour:
- Reset (async, rst_n=0): rd_en=0, m_valid=0, m_data=0, busy=0, buffer count=0, inflight_q=0, state=IDLE. Pointers=0.
- rd_en is combinational: en && !flush && !empty && (state==RUN) && (cnt + inflight_q < BUF_DEPTH). It does not depend on m_ready.
- inflight_q is a register set to rd_en each cycle. When inflight_q=1 and no flush, rd_data is written at the buffer tail that edge.
- m_valid = (cnt != 0). m_data = head entry, registered and stable while m_valid && !m_ready.
- Pop occurs on m_valid && m_ready. Push and pop in the same cycle leave cnt unchanged and both pointers advance. Pointers wrap at BUF_DEPTH-1 -> 0.
- Latency: rd_en in cycle N -> rd_data in N+1 -> m_valid in N+2. With m_ready held at 1, throughput is 1 word/cycle.
- FSM states:
  - IDLE -> RUN when en=1.
  - RUN -> STOP when en=0.
  - STOP: no new reads; waits for inflight_q=0; then -> IDLE. If en=1 returns while in STOP -> RUN.
  - Buffered words continue to drain to the stream in every state.
- Flush (one cycle): cnt<=0, pointers<=0, and any arriving in-flight word is dropped. rd_en=0 that cycle. State -> RUN if en else IDLE. Flush wins over a simultaneous push or pop. m_valid=0 the next cycle.
- Boundaries:
  - Buffer full (cnt + inflight = BUF_DEPTH) holds rd_en=0.
  - empty=1 holds rd_en=0; no underflow read is ever issued.
  - Reset mid-transfer drops everything immediately.
- Arithmetic: cnt width $clog2(BUF_DEPTH+1); the sum cnt+inflight_q is computed one bit wider.

Optional Feature:
FIFO_RD_STATS_EN
- Defined: adds outputs word_cnt[31:0] and underrun_cnt[31:0], both cleared only by reset and saturating at all-ones.
  - word_cnt increments on each stream handshake.
  - underrun_cnt increments each cycle with en=1, empty=1, cnt=0 and inflight_q=0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package fifo_rd_pkg:
  - state enum rd_state_e {IDLE, RUN, STOP}
  - localparam MIN_BUF_DEPTH=3
  - function for count width.
- Sub-module fifo_rd_skid_buf (DATA_W, BUF_DEPTH): circular buffer with push, pop, flush, cnt, head data. The top holds the FSM, read issue, inflight tracking and stats.

Test Plan:
- FIFO preloaded with 0x11,0x22,0x33,0x44, en=1, m_ready=1 -> rd_en high 4 consecutive cycles; m_valid first at rd_en+2; m_data sequence 11,22,33,44 on consecutive cycles; rd_en never high with empty=1.
- m_ready=0 for 10 cycles with FIFO holding 8 words -> exactly 3 reads issued, cnt=3, m_data=first word stable. Raise m_ready -> remaining 8 words delivered in order with no gaps.
- FIFO empty, en=1 for 5 cycles -> rd_en=0 and m_valid=0 throughout. With the macro defined, underrun_cnt=5.
- Flush asserted in the cycle an in-flight word (0xAA) arrives with cnt=2 -> next cycle m_valid=0, 0xAA never appears, next delivered word is the following FIFO entry.
- en dropped with a read in flight -> state STOP, that word is still delivered, then IDLE; busy=0 once the buffer drains; no further rd_en.
- rst_n pulsed low mid-stream with cnt=2 -> rd_en, m_valid, m_data, busy all 0 asynchronously; after release no stale data is delivered.
